// File: rtl/md_pkg.sv
// md_pkg: opcodes, FSM states and helpers shared by the multiply/divide unit.
package md_pkg;
  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
  typedef enum logic {IDLE, BUSY} state_t;
  function automatic logic is_multi(input logic [3:0] op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  endfunction
endpackage

// File: rtl/md_unit_multi_if.sv
// md_unit_multi_if: E-stage request/response bundle of the multiply/divide unit.
interface md_unit_multi_if #(parameter int WIDTH = 32);
  logic [3:0] md_op;
  logic start;
  logic flush;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] md_out;
  modport master(output md_op, start, flush, rs, rt, input busy, hi, lo, md_out);
  modport slave(input md_op, start, flush, rs, rt, output busy, hi, lo, md_out);
endinterface

// File: rtl/md_arith.sv
// md_arith: combinational product/accumulate/divide datapath producing the next HI/LO.
module md_arith
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_zero
);
  logic w_sgn, w_neg_a, w_neg_b;
  logic [2*WIDTH-1:0] w_prod, w_acc;
  logic [WIDTH-1:0] w_ua, w_ub, w_uq, w_ur, w_q, w_r;
  // Signed divide runs on magnitudes so most-negative / -1 wraps cleanly to most-negative.
  always_comb begin
    w_sgn = op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
    w_neg_a = w_sgn & rs[WIDTH-1];
    w_neg_b = w_sgn & rt[WIDTH-1];
    w_prod = {{WIDTH{w_neg_a}}, rs} * {{WIDTH{w_neg_b}}, rt};
    w_acc = {hi, lo};
    w_ua = w_neg_a ? -rs : rs;
    w_ub = w_neg_b ? -rt : rt;
    w_ub = w_ub == '0 ? WIDTH'(1) : w_ub;
    w_uq = w_ua / w_ub;
    w_ur = w_ua % w_ub;
    w_q = (w_neg_a ^ w_neg_b) ? -w_uq : w_uq;
    w_r = w_neg_a ? -w_ur : w_ur;
    div_zero = op inside {OP_DIV, OP_DIVU} && rt == '0;
    {res_hi, res_lo} = op inside {OP_MADD, OP_MADDU} ? w_acc + w_prod :
                       op inside {OP_MSUB, OP_MSUBU} ? w_acc - w_prod :
                       op inside {OP_DIV, OP_DIVU}   ? {w_r, w_q} : w_prod;
  end
endmodule

// File: rtl/md_unit_multi.sv
// md_unit_multi: iterative-latency multiply/divide unit with HI/LO, MAC and flush.
module md_unit_multi
  import md_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic clk,
  input logic reset,
  md_unit_multi_if.slave bus
);
  localparam int MAXC = MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC) + 1;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo, r_p_hi, r_p_lo, w_res_hi, w_res_lo;
  logic r_p_dz, w_dz, w_launch, w_last, w_done, w_mt_ok;
  md_arith #(.WIDTH(WIDTH)) u_arith (
    .op(bus.md_op), .rs(bus.rs), .rt(bus.rt), .hi(r_hi), .lo(r_lo),
    .res_hi(w_res_hi), .res_lo(w_res_lo), .div_zero(w_dz)
  );
  always_ff @(posedge clk) r_state <= !reset ? IDLE : w_next;
  always_comb begin
    w_launch = r_state == IDLE && bus.start && is_multi(bus.md_op) && !bus.flush;
    w_last = r_state == BUSY && r_cnt == CW'(1);
    w_done = w_last && !bus.flush;
    w_mt_ok = r_state == IDLE && !bus.flush;
    w_next = r_state == IDLE ? (w_launch ? BUSY : IDLE) : (bus.flush || w_last ? IDLE : BUSY);
  end
  // Result is computed at launch and held pending so flush/reset can drop it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
      r_hi <= '0;
      r_lo <= '0;
      r_p_hi <= '0;
      r_p_lo <= '0;
      r_p_dz <= 1'b0;
    end else begin
      r_cnt <= w_launch ? (bus.md_op inside {OP_DIV, OP_DIVU} ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES)) :
               (bus.flush || r_cnt == '0) ? '0 : r_cnt - 1'b1;
      if (w_launch) begin
        r_p_hi <= w_res_hi;
        r_p_lo <= w_res_lo;
        r_p_dz <= w_dz;
      end
      if (w_done && !r_p_dz) begin
        r_hi <= r_p_hi;
        r_lo <= r_p_lo;
      end else if (w_mt_ok) begin
        if (bus.md_op == OP_MTHI) r_hi <= bus.rs;
        if (bus.md_op == OP_MTLO) r_lo <= bus.rs;
      end
    end
  end
  assign bus.busy = r_state == BUSY;
  assign bus.hi = r_hi;
  assign bus.lo = r_lo;
  assign bus.md_out = bus.md_op == OP_MFHI ? r_hi : bus.md_op == OP_MFLO ? r_lo : '0;
endmodule

// File: tb/tb_md_unit_multi.sv
// tb_md_unit_multi: directed vector table plus flush/reset/throughput sequences.
module tb_md_unit_multi;
  import md_pkg::*;
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
    string       nm;
  } vec_t;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
  vec_t v[13];
  md_unit_multi_if #(.WIDTH(32)) b32 ();
  md_unit_multi_if #(.WIDTH(16)) b16 ();
  md_unit_multi u32 (.clk(clk), .reset(reset), .bus(b32));
  md_unit_multi #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(3)) u16 (.clk(clk), .reset(reset), .bus(b16));
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic go(input logic w, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
    if (w) begin
      b16.md_op = op; b16.rs = a[15:0]; b16.rt = b[15:0]; b16.start = is_multi(op);
    end else begin
      b32.md_op = op; b32.rs = a; b32.rt = b; b32.start = is_multi(op);
    end
    @(negedge clk);
    b16.start = 1'b0; b16.md_op = OP_NONE;
    b32.start = 1'b0; b32.md_op = OP_NONE;
    n = 0;
    while ((w ? b16.busy : b32.busy) && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask
  initial begin
    int n;
    v[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 5,  "mult_neg"};
    v[1]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       10, "divu_100_7"};
    v[2]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 10, "div_min_m1"};
    v[3]  = '{OP_DIV,   32'd5,        32'd0,        32'd0,        32'h80000000, 10, "div_zero"};
    v[4]  = '{OP_MTHI,  32'd0,        32'd0,        32'd0,        32'h80000000, 0,  "mthi_0"};
    v[5]  = '{OP_MTLO,  32'hFFFFFFFF, 32'd0,        32'd0,        32'hFFFFFFFF, 0,  "mtlo_ff"};
    v[6]  = '{OP_MADDU, 32'd1,        32'd1,        32'd1,        32'd0,        5,  "maddu_carry"};
    v[7]  = '{OP_MSUBU, 32'd1,        32'd1,        32'd0,        32'hFFFFFFFF, 5,  "msubu_borrow"};
    v[8]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10, "div_m7_2"};
    v[9]  = '{OP_MADD,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFF7, 5,  "madd_neg"};
    v[10] = '{OP_MSUB,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFD, 5,  "msub_neg"};
    v[11] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5,  "multu_max"};
    v[12] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10, "div_7_m2"};
    reset = 1'b0;
    b32.md_op = OP_NONE; b32.start = 1'b0; b32.flush = 1'b0; b32.rs = '0; b32.rt = '0;
    b16.md_op = OP_NONE; b16.start = 1'b0; b16.flush = 1'b0; b16.rs = '0; b16.rt = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", b32.busy, 0);
    check("rst_hi", b32.hi, 0);
    check("rst_lo", b32.lo, 0);
    check("rst_md_out", b32.md_out, 0);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      go(1'b0, v[i].op, v[i].a, v[i].b, n);
      check({v[i].nm, "_busy"}, n, v[i].n);
      check({v[i].nm, "_hi"}, b32.hi, v[i].hi);
      check({v[i].nm, "_lo"}, b32.lo, v[i].lo);
    end
    go(1'b0, OP_MTHI, 32'h12345678, 0, n);
    go(1'b0, OP_MTLO, 32'h9ABCDEF0, 0, n);
    b32.md_op = OP_MFHI; #1;
    check("mfhi", b32.md_out, 32'h12345678);
    b32.md_op = OP_MFLO; #1;
    check("mflo", b32.md_out, 32'h9ABCDEF0);
    b32.md_op = OP_NONE; #1;
    check("md_out_none", b32.md_out, 0);
    // flush in the third busy cycle of mult 3*4
    b32.md_op = OP_MULT; b32.rs = 3; b32.rt = 4; b32.start = 1'b1;
    @(negedge clk);
    b32.start = 1'b0; b32.md_op = OP_NONE;
    repeat (2) @(negedge clk);
    check("flush_pre_busy", b32.busy, 1);
    b32.flush = 1'b1;
    @(negedge clk);
    b32.flush = 1'b0;
    check("flush_busy", b32.busy, 0);
    repeat (6) @(negedge clk);
    check("flush_hi", b32.hi, 32'h12345678);
    check("flush_lo", b32.lo, 32'h9ABCDEF0);
    // start and flush together
    b32.md_op = OP_MULT; b32.start = 1'b1; b32.flush = 1'b1;
    @(negedge clk);
    b32.md_op = OP_NONE; b32.start = 1'b0; b32.flush = 1'b0;
    n = 0;
    for (int i = 0; i < 7; i++) begin
      n += int'(b32.busy);
      @(negedge clk);
    end
    check("sflush_busy_cycles", n, 0);
    check("sflush_lo", b32.lo, 32'h9ABCDEF0);
    // reset in the middle of divu
    b32.md_op = OP_DIVU; b32.rs = 100; b32.rt = 7; b32.start = 1'b1;
    @(negedge clk);
    b32.md_op = OP_NONE; b32.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("rstmid_busy", b32.busy, 0);
    check("rstmid_hi", b32.hi, 0);
    check("rstmid_lo", b32.lo, 0);
    repeat (12) @(negedge clk);
    check("rstmid_lo_later", b32.lo, 0);
    b32.md_op = OP_MFHI; #1;
    check("rstmid_mfhi", b32.md_out, 0);
    // divu with a start and an mthi arriving while busy
    b32.md_op = OP_DIVU; b32.rs = 100; b32.rt = 7; b32.start = 1'b1;
    @(negedge clk);
    b32.md_op = OP_NONE; b32.start = 1'b0;
    n = 0;
    while (b32.busy && n < 50) begin
      n++;
      if (n == 1) begin b32.md_op = OP_MULT; b32.rs = 3; b32.rt = 4; b32.start = 1'b1; end
      if (n == 2) begin b32.md_op = OP_MTHI; b32.rs = 32'hDEADBEEF; b32.start = 1'b0; end
      if (n == 3) b32.md_op = OP_NONE;
      @(negedge clk);
    end
    check("busyign_cycles", n, 10);
    check("busyign_hi", b32.hi, 2);
    check("busyign_lo", b32.lo, 14);
    // narrow instance: WIDTH=16, MUL_CYCLES=1, DIV_CYCLES=3
    go(1'b1, OP_MULTU, 32'hFFFF, 32'hFFFF, n);
    check("w16_multu_busy", n, 1);
    check("w16_multu_hi", b16.hi, 16'hFFFE);
    check("w16_multu_lo", b16.lo, 16'h0001);
    go(1'b1, OP_DIVU, 32'd1000, 32'd7, n);
    check("w16_divu_busy", n, 3);
    check("w16_divu_hi", b16.hi, 16'd6);
    check("w16_divu_lo", b16.lo, 16'd142);
    b16.md_op = OP_MULTU; b16.rs = 2; b16.rt = 3; b16.start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("w16_b2b_%0d", i), b16.busy, (i % 2 == 0) ? 1 : 0);
    end
    b16.start = 1'b0; b16.md_op = OP_NONE;
    @(negedge clk);
    check("w16_b2b_busy_end", b16.busy, 0);
    check("w16_b2b_lo", b16.lo, 16'd6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
